// File: rtl/uart_tx_buffer_if.sv
// Putch-side push handshake and paced UART output of uart_tx_buffer, bundled with status.
// The slave modport is the buffer; the master modport is the core/sink side.
interface uart_tx_buffer_if #(
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          putch_valid;
  logic [7:0]    putch_ch;
  logic          putch_ready;
  logic          uart_out_valid;
  logic [7:0]    uart_out_ch;
  logic [CW-1:0] count;
  logic [15:0]   drop_cnt;

  modport slave (
    input  putch_valid, putch_ch,
    output putch_ready, uart_out_valid, uart_out_ch, count, drop_cnt
  );

  modport master (
    output putch_valid, putch_ch,
    input  putch_ready, uart_out_valid, uart_out_ch, count, drop_cnt
  );
endinterface

// File: rtl/uart_tx_buffer.sv
// Putch character FIFO that emits one char per GAP cycles as a single-cycle pulse.
// Optional macro UART_TX_CRLF_EN expands each LF into CR then LF.
module uart_tx_buffer #(
  parameter int DEPTH = 16,
  parameter int GAP   = 4
) (
  input  logic             clock,
  input  logic             reset,
  uart_tx_buffer_if.slave  bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int AW = $clog2(DEPTH);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic {IDLE, PACE} state_t;

  state_t        r_state, w_state_nxt;
  logic [GW-1:0] r_gap_cnt, w_gap_nxt;
  logic [CW-1:0] r_count;
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [7:0]    r_mem [DEPTH];
  logic [15:0]   r_drop_cnt;
  logic          r_out_valid;
  logic [7:0]    r_out_ch;

  logic          w_ready, w_push, w_emit, w_pop;
  logic [7:0]    w_head, w_out_ch;

  // Readiness comes from the registered count only: a pop on the same edge does not free a slot.
  assign w_ready = (r_count != CW'(DEPTH));
  assign w_push  = bus.putch_valid && w_ready;
  assign w_head  = r_mem[r_rd_ptr];

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= IDLE;
      r_gap_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_gap_cnt <= w_gap_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gap_nxt   = r_gap_cnt;
    w_emit      = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_count != '0) begin
          w_emit      = 1'b1;
          w_gap_nxt   = GW'(GAP - 1);
          w_state_nxt = (GAP > 1) ? PACE : IDLE;
        end
      end
      PACE: begin
        w_gap_nxt = r_gap_cnt - 1'b1;
        if (r_gap_cnt == GW'(1)) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

`ifdef UART_TX_CRLF_EN
  logic r_cr_done, w_is_cr;

  // A CR occupies its own emit slot while the LF stays at the head.
  assign w_is_cr  = w_emit && (w_head == 8'h0A) && !r_cr_done;
  assign w_pop    = w_emit && !w_is_cr;
  assign w_out_ch = w_is_cr ? 8'h0D : w_head;

  always_ff @(posedge clock) begin
    if (reset)       r_cr_done <= 1'b0;
    else if (w_emit) r_cr_done <= w_is_cr;
  end
`else
  assign w_pop    = w_emit;
  assign w_out_ch = w_head;
`endif

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.putch_ch;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_count     <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_drop_cnt  <= '0;
      r_out_valid <= 1'b0;
      r_out_ch    <= '0;
    end else begin
      r_count     <= r_count + CW'(w_push) - CW'(w_pop);
      r_out_valid <= w_emit;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_emit) r_out_ch <= w_out_ch;
      if (bus.putch_valid && !w_ready && (r_drop_cnt != 16'hFFFF))
        r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign bus.putch_ready    = w_ready;
  assign bus.uart_out_valid = r_out_valid;
  assign bus.uart_out_ch    = r_out_ch;
  assign bus.count          = r_count;
  assign bus.drop_cnt       = r_drop_cnt;
endmodule

// File: tb/tb_uart_tx_buffer.sv
// Directed bench for uart_tx_buffer (DEPTH=16, GAP=4): per-cycle vector table plus
// sequences for fill/drop, reset mid-stream, pointer wrap and LF handling.
module tb_uart_tx_buffer;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  logic [7:0] q_ch [$];
  int         q_cyc [$];
  logic [7:0] exp_q [$];

  uart_tx_buffer_if #(.DEPTH(16)) bus ();

  uart_tx_buffer #(.DEPTH(16), .GAP(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (bus.uart_out_valid) begin
      q_ch.push_back(bus.uart_out_ch);
      q_cyc.push_back(cyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       vld;
    logic [7:0] ch;
    logic       exp_v;
    logic [7:0] exp_ch;
    logic [4:0] exp_cnt;
    logic       exp_rdy;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.putch_valid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic push(input logic [7:0] c);
    bus.putch_valid = 1'b1;
    bus.putch_ch    = c;
    @(posedge clock); #1;
    bus.putch_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clock); #1;
    end
  endtask

  task automatic cmp_stream(input string name);
    chk({name, "_len"}, q_ch.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < q_ch.size(); k++)
      chk(name, q_ch[k], exp_q[k]);
  endtask

  initial begin
    bus.putch_valid = 1'b0;
    bus.putch_ch    = 8'h00;

    //          vld  ch     ev  ech    cnt  rdy
    vecs[0]  = '{1'b1, 8'h41, 1'b0, 8'h00, 5'd1, 1'b1};
    vecs[1]  = '{1'b1, 8'h42, 1'b1, 8'h41, 5'd1, 1'b1};
    vecs[2]  = '{1'b1, 8'h43, 1'b0, 8'h00, 5'd2, 1'b1};
    vecs[3]  = '{1'b0, 8'h00, 1'b0, 8'h00, 5'd2, 1'b1};
    vecs[4]  = '{1'b0, 8'h00, 1'b0, 8'h00, 5'd2, 1'b1};
    vecs[5]  = '{1'b0, 8'h00, 1'b1, 8'h42, 5'd1, 1'b1};
    vecs[6]  = '{1'b0, 8'h00, 1'b0, 8'h00, 5'd1, 1'b1};
    vecs[7]  = '{1'b0, 8'h00, 1'b0, 8'h00, 5'd1, 1'b1};
    vecs[8]  = '{1'b0, 8'h00, 1'b0, 8'h00, 5'd1, 1'b1};
    vecs[9]  = '{1'b0, 8'h00, 1'b1, 8'h43, 5'd0, 1'b1};
    vecs[10] = '{1'b0, 8'h00, 1'b0, 8'h00, 5'd0, 1'b1};
    vecs[11] = '{1'b0, 8'h00, 1'b0, 8'h00, 5'd0, 1'b1};

    idle(2);
    do_reset();
    chk("rst_ready", bus.putch_ready, 1);
    chk("rst_valid", bus.uart_out_valid, 0);
    chk("rst_ch",    bus.uart_out_ch, 0);
    chk("rst_count", bus.count, 0);
    chk("rst_drop",  bus.drop_cnt, 0);

    // Single char + ABC pacing, cycle by cycle
    for (int i = 0; i < 12; i++) begin
      bus.putch_valid = vecs[i].vld;
      bus.putch_ch    = vecs[i].ch;
      @(posedge clock); #1;
      chk($sformatf("vec%0d_valid", i), bus.uart_out_valid, vecs[i].exp_v);
      if (vecs[i].exp_v) chk($sformatf("vec%0d_ch", i), bus.uart_out_ch, vecs[i].exp_ch);
      chk($sformatf("vec%0d_count", i), bus.count, vecs[i].exp_cnt);
      chk($sformatf("vec%0d_ready", i), bus.putch_ready, vecs[i].exp_rdy);
    end
    bus.putch_valid = 1'b0;

    // LF handling
    do_reset();
    q_ch.delete(); q_cyc.delete(); exp_q.delete();
    push(8'h61);
    push(8'h0A);
    idle(20);
    exp_q.push_back(8'h61);
`ifdef UART_TX_CRLF_EN
    exp_q.push_back(8'h0D);
`endif
    exp_q.push_back(8'h0A);
    cmp_stream("crlf");
    for (int k = 1; k < q_cyc.size(); k++)
      chk("crlf_spacing", q_cyc[k] - q_cyc[k-1], 4);
    chk("crlf_count", bus.count, 0);

    // Fill/drop: 30 back-to-back pushes; pushes 21,23,24,25,27,28,29 meet a full FIFO
    do_reset();
    q_ch.delete(); q_cyc.delete(); exp_q.delete();
    for (int i = 0; i < 30; i++) begin
      bus.putch_valid = 1'b1;
      bus.putch_ch    = 8'h30 + 8'(i);
      @(posedge clock); #1;
      if (i == 19) chk("full_count19", bus.count, 15);
      if (i == 20) begin
        chk("full_count20", bus.count, 16);
        chk("full_ready20", bus.putch_ready, 0);
      end
      if (i == 21) chk("full_ready21", bus.putch_ready, 1);
      if (!(i inside {21, 23, 24, 25, 27, 28, 29})) exp_q.push_back(8'h30 + 8'(i));
    end
    bus.putch_valid = 1'b0;
    chk("full_drop", bus.drop_cnt, 7);
    idle(100);
    cmp_stream("full_order");
    chk("full_drain_count", bus.count, 0);
    for (int k = 1; k < q_cyc.size(); k++)
      chk("full_period", q_cyc[k] - q_cyc[k-1], 4);

    // Reset mid-stream with nonzero drop count
    for (int i = 0; i < 5; i++) push(8'h70 + 8'(i));
    idle(2);
    do_reset();
    chk("mrst_count", bus.count, 0);
    chk("mrst_valid", bus.uart_out_valid, 0);
    chk("mrst_drop",  bus.drop_cnt, 0);
    q_ch.delete(); q_cyc.delete(); exp_q.delete();
    idle(10);
    chk("mrst_silent", q_ch.size(), 0);
    push(8'h5A);
    idle(20);
    exp_q.push_back(8'h5A);
    cmp_stream("mrst_after");

    // Pointer wrap: 4 bursts of 10
    do_reset();
    q_ch.delete(); q_cyc.delete(); exp_q.delete();
    for (int b = 0; b < 4; b++) begin
      for (int j = 0; j < 10; j++) begin
        push(8'h80 + 8'(b * 10 + j));
        exp_q.push_back(8'h80 + 8'(b * 10 + j));
      end
      idle(45);
      chk($sformatf("wrap_count_b%0d", b), bus.count, 0);
    end
    cmp_stream("wrap_order");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
